// File: rtl/booth_mult_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digits and
// the 3-bit window recoder.
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_e;

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_e booth_recode(input logic [2:0] i_win);
        booth_digit_e digit;
        case (i_win)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Combinational radix-4 Booth partial-product selector: picks 0, +-A or +-2A
// from the extended multiplicand according to the recoded window.
module booth_r4_encoder
    import booth_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       i_window,
    input  logic [WIDTH+1:0] i_mcand,
    output logic [WIDTH+2:0] o_pp_c
);

    localparam int unsigned PPW = WIDTH + 3;

    booth_digit_e   w_digit;
    logic [PPW-1:0] w_a1;
    logic [PPW-1:0] w_a2;

    assign w_digit = booth_recode(i_window);
    assign w_a1    = {i_mcand[WIDTH+1], i_mcand};
    assign w_a2    = {i_mcand, 1'b0};

    always_comb begin
        o_pp_c = '0;
        case (w_digit)
            POS1:    o_pp_c = w_a1;
            POS2:    o_pp_c = w_a2;
            NEG1:    o_pp_c = PPW'(~w_a1 + PPW'(1));
            NEG2:    o_pp_c = PPW'(~w_a2 + PPW'(1));
            default: o_pp_c = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// Sequential radix-4 Booth multiplier with valid/ready handshakes and
// per-operation signed/unsigned mode. Optional macro: BOOTH_ZERO_SKIP_EN.
module booth_r4_seq_multiplier
    import booth_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned ITER  = WIDTH / 2 + 1;
    localparam int unsigned EW    = WIDTH + 2;
    localparam int unsigned PPW   = WIDTH + 3;
    localparam int unsigned ACC_W = 2 * WIDTH + 4;
    localparam int unsigned CNT_W = $clog2(ITER + 1);

    state_e             r_state;
    logic [EW-1:0]      r_mcand;
    logic [EW:0]        r_mplier;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic [EW-1:0]      w_a_ext;
    logic [EW-1:0]      w_b_ext;
    logic [PPW-1:0]     w_pp;
    logic [ACC_W-1:0]   w_pp_ext;
    logic [ACC_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_cnt_init;
    logic               w_last;

    assign w_a_ext = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign w_b_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

    booth_r4_encoder #(.WIDTH(WIDTH)) u_enc (
        .i_window (r_mplier[2:0]),
        .i_mcand  (r_mcand),
        .o_pp_c   (w_pp)
    );

    // Partial product weighted by 4^i, added into the two's-complement accumulator.
    assign w_pp_ext   = {{(ACC_W-PPW){w_pp[PPW-1]}}, w_pp};
    assign w_acc_next = r_acc + (w_pp_ext << {r_cnt, 1'b0});
    assign w_last     = (r_cnt == CNT_W'(ITER - 1));

`ifdef BOOTH_ZERO_SKIP_EN
    // A zero operand yields only zero partial products, so one step suffices.
    assign w_cnt_init = (a == '0 || b == '0) ? CNT_W'(ITER - 1) : '0;
`else
    assign w_cnt_init = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_mcand  <= w_a_ext;
                        r_mplier <= {w_b_ext, 1'b0};
                        r_acc    <= '0;
                        r_cnt    <= w_cnt_init;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= {{2{r_mplier[EW]}}, r_mplier[EW:2]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        product   <= w_acc_next[2*WIDTH-1:0];
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Self-checking bench for booth_r4_seq_multiplier: WIDTH=32 and WIDTH=8 instances
// checked against plain-arithmetic products, latency, handshake and reset behaviour.
module tb_booth_r4_seq_multiplier;

    localparam int ITER32 = 17;
    localparam int ITER8  = 5;

    logic clk = 1'b0;
    logic rst_n;

    logic        in_valid32, in_ready32, sgn32, out_valid32, out_ready32, busy32;
    logic [31:0] a32, b32;
    logic [63:0] product32;

    logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_r4_seq_multiplier #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .is_signed(sgn32), .a(a32), .b(b32), .out_valid(out_valid32),
        .out_ready(out_ready32), .product(product32), .busy(busy32)
    );

    booth_r4_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .is_signed(sgn8), .a(a8), .b(b8), .out_valid(out_valid8),
        .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model32(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        longint unsigned ux, uy;
        if (sgn) begin
            sx = $signed(x);
            sy = $signed(y);
            return 64'(sx * sy);
        end
        ux = 64'(x);
        uy = 64'(y);
        return ux * uy;
    endfunction

    function automatic logic [15:0] model8(input bit sgn, input logic [7:0] x, input logic [7:0] y);
        int sx, sy;
        if (sgn) begin
            sx = int'($signed(x));
            sy = int'($signed(y));
        end else begin
            sx = int'(x);
            sy = int'(y);
        end
        return 16'(sx * sy);
    endfunction

    // Issue one op, scramble inputs while busy, wait for result, apply bp cycles of backpressure.
    task automatic run32(input bit sgn, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [63:0] expv, input int bp, input string tag);
        int lat;
        int exp_lat;
        exp_lat = ITER32;
`ifdef BOOTH_ZERO_SKIP_EN
        if (aa == 0 || bb == 0) exp_lat = 1;
`endif
        chk({tag, "_rdy"}, 64'(in_ready32), 64'd1);
        in_valid32 = 1'b1; sgn32 = sgn; a32 = aa; b32 = bb;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid32 && lat < 200) begin
            a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        in_valid32 = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_prod"}, product32, expv);
        chk({tag, "_busy"}, 64'(busy32), 64'd1);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk({tag, "_bp_prod"}, product32, expv);
            chk({tag, "_bp_vld"}, 64'(out_valid32), 64'd1);
            chk({tag, "_bp_rdy"}, 64'(in_ready32), 64'd0);
        end
        out_ready32 = 1'b1;
        @(posedge clk); #1;
        out_ready32 = 1'b0;
        chk({tag, "_post_vld"}, 64'(out_valid32), 64'd0);
        chk({tag, "_post_rdy"}, 64'(in_ready32), 64'd1);
        chk({tag, "_post_prod"}, product32, expv);
    endtask

    task automatic run8(input bit sgn, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [15:0] expv, input string tag);
        int lat;
        int exp_lat;
        exp_lat = ITER8;
`ifdef BOOTH_ZERO_SKIP_EN
        if (aa == 0 || bb == 0) exp_lat = 1;
`endif
        in_valid8 = 1'b1; sgn8 = sgn; a8 = aa; b8 = bb;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin
            a8 = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_prod"}, 64'(product8), 64'(expv));
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk({tag, "_post_rdy"}, 64'(in_ready8), 64'd1);
    endtask

    initial begin
        bit          sgn;
        logic [31:0] ra, rb;
        logic [7:0]  sa, sb;

        rst_n = 1'b0;
        in_valid32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0; out_ready32 = 1'b0;
        in_valid8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0; out_ready8  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy32", 64'(in_ready32), 64'd1);
        chk("rst_vld32", 64'(out_valid32), 64'd0);
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_prod32", product32, 64'd0);
        chk("rst_prod8", 64'(product8), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run32(1'b1, 32'd12345, 32'd6789, 64'd83810205, 0, "s_pos");
        run32(1'b1, -32'sd12345, 32'd6789, -64'sd83810205, 0, "s_neg");
        run32(1'b1, 32'h8000_0000, 32'h8000_0000, 64'd4611686018427387904, 0, "s_minmin");
        run32(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, -64'sd4611686016279904256, 0, "s_maxmin");
        run32(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, -64'sd2147483647, 0, "s_maxm1");
        run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, "u_ones");
        run32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 0, "s_ones");
        run32(1'b0, 32'd0, 32'd77, 64'd0, 0, "u_zero");

        // Backpressure, then a back-to-back second operation.
        run32(1'b1, 32'd1000, -32'sd3, -64'sd3000, 10, "bp_first");
        run32(1'b0, 32'd65536, 32'd65537, 64'd4295032832, 0, "bp_second");

        // Asynchronous reset in the middle of a calculation.
        in_valid32 = 1'b1; sgn32 = 1'b1; a32 = 32'd987654321; b32 = 32'd123456789;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rdy", 64'(in_ready32), 64'd1);
        chk("arst_vld", 64'(out_valid32), 64'd0);
        chk("arst_busy", 64'(busy32), 64'd0);
        chk("arst_prod", product32, 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run32(1'b1, 32'd987654321, 32'd123456789, 64'd121932631112635269, 0, "arst_rerun");

        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 8 == 3) ra = '0;
            if (i % 8 == 5) rb = '0;
            if (i % 8 == 6) rb = 32'h8000_0000;
            run32(sgn, ra, rb, model32(sgn, ra, rb), i % 3, $sformatf("rnd32_%0d", i));
        end

        run8(1'b1, 8'h80, 8'h80, 16'd16384, "w8_minmin");
        run8(1'b0, 8'hFF, 8'hFF, 16'd65025, "w8_ones");
        run8(1'b0, 8'd0, 8'd77, 16'd0, "w8_zero");
        for (int i = 0; i < 16; i++) begin
            sgn = 1'($urandom_range(0, 1));
            sa  = 8'($urandom);
            sb  = 8'($urandom);
            run8(sgn, sa, sb, model8(sgn, sa, sb), $sformatf("rnd8_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
